lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width, legal range 3..32.
REQ-002 SHALL have parameter TAPS, default 8'hB8: WIDTH-bit feedback tap mask.
REQ-003 SHALL have parameter SEED, default 1: WIDTH-bit reset/recovery state, nonzero.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1: advance state one step this cycle.
REQ-007 SHALL have port load, input, 1: load seed_in this cycle.
REQ-008 SHALL have port seed_in, input, WIDTH: value taken on load.
REQ-009 SHALL have port mode, input, 1: step form; 0 Fibonacci, 1 Galois.
REQ-010 SHALL have port out, output, WIDTH: current register state.
REQ-011 SHALL have port bit_out, output, 1: serial bit, equal to out[0].
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse when the sequence returns to the active seed.
REQ-013 SHALL have port period, output, WIDTH: step count of the last completed cycle.
REQ-014 SHALL have port lockup, output, 1: one-cycle pulse on all-zero recovery.

Function
REQ-015 Fibonacci step SHALL be fb = XOR-reduce(out AND TAPS), next = {out[WIDTH-2:0], fb}.
REQ-016 Galois step SHALL be next = (out >> 1) XOR (out[0] ? TAPS : 0).
REQ-017 mode SHALL be sampled on each advancing edge; a change affects the next step only, with no pipeline flush.
REQ-018 Priority per edge SHALL be rst > load > en; with en=0 and load=0, out and all counters hold.
REQ-019 On load with seed_in nonzero: out <= seed_in, active_seed <= seed_in, step counter <= 0, no wrap pulse.
REQ-020 On load with seed_in zero: out <= SEED, active_seed <= SEED, step counter <= 0, lockup pulses next cycle.
REQ-021 When en=1 and out is all-zero, e.g. after a TAPS misuse: out <= SEED, active_seed <= SEED, step counter <= 0, lockup pulses; no normal step.
REQ-022 Step counter (WIDTH bits) SHALL increment on each normal advance.
REQ-023 When an advance produces next == active_seed: wrap pulses the following cycle, period <= counter+1, counter <= 0.
REQ-024 If the counter saturates at all-ones without a wrap, it SHALL hold, and period SHALL not update.
REQ-025 wrap and lockup SHALL be registered, high exactly one cycle per event, and never high together.
REQ-026 out SHALL change only on a clock edge or on rst; no combinational path from inputs to outputs.
REQ-027 Default parameters SHALL give a maximal 255-step sequence in both modes.

Reset
REQ-028 Asserting rst asynchronously SHALL force out=SEED, active_seed=SEED, counter=0, period=0, wrap=0, lockup=0.
REQ-029 While rst is high, en and load SHALL be ignored.
REQ-030 The first advance SHALL occur on the first posedge with rst low and en high.
REQ-031 Asserting rst mid-sequence SHALL abandon the sequence, with no wrap or lockup pulse on release.

Verification
REQ-032 Reset and Galois step: defaults, release rst, mode=1, en=1 -> out 0x01, 0xB8, 0x5C on successive edges.
REQ-033 Fibonacci step: load 0x80, mode=0, one en -> out=0x01; from 0x01, one en -> out=0x02.
REQ-034 Full period: mode=1, en held from seed 0x01 -> wrap pulses once after 255 advances, period=255, out=0x01; repeat for mode=0.
REQ-035 Zero-seed load: load=1, seed_in=0x00 -> out=0x01, lockup pulses one cycle, wrap stays low.
REQ-036 Load versus enable: load=1, en=1, seed_in=0x3C -> out=0x3C, counter=0; the next en edge steps from 0x3C.
REQ-037 Async reset mid-run: assert rst between edges at step 100 -> out=0x01 and period=0 immediately; no pulses after release.

Source files
------------

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR with seed load, zero-state recovery and period measurement
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    logic [WIDTH-1:0] active_seed;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic             fib_fb;
    logic             cnt_max;
    logic             out_zero;

    always_comb begin
        fib_fb    = ^(out & TAPS);
        fib_next  = {out[WIDTH-2:0], fib_fb};
        gal_next  = (out >> 1) ^ (out[0] ? TAPS : '0);
        step_next = mode ? gal_next : fib_next;
        cnt_max   = &cnt;
        out_zero  = (out == '0);
    end

    assign bit_out = out[0];

    // wrap and lockup default low each edge so every event yields a single-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out         <= SEED;
            active_seed <= SEED;
            cnt         <= '0;
            period      <= '0;
            wrap        <= 1'b0;
            lockup      <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                cnt <= '0;
                if (seed_in != '0) begin
                    out         <= seed_in;
                    active_seed <= seed_in;
                end else begin
                    out         <= SEED;
                    active_seed <= SEED;
                    lockup      <= 1'b1;
                end
            end else if (en) begin
                if (out_zero) begin
                    // all-zero is a dead state for an XOR LFSR; restart from the seed
                    out         <= SEED;
                    active_seed <= SEED;
                    cnt         <= '0;
                    lockup      <= 1'b1;
                end else begin
                    out <= step_next;
                    if (step_next == active_seed) begin
                        wrap <= 1'b1;
                        cnt  <= '0;
                        if (!cnt_max) begin
                            period <= cnt + 1'b1;
                        end
                    end else if (!cnt_max) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed table-driven bench for lfsr_gen with default parameters
module tb_lfsr_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] seed_in;
    logic       mode;
    logic [7:0] out;
    logic       bit_out;
    logic       wrap;
    logic [7:0] period;
    logic       lockup;

    int checks   = 0;
    int failures = 0;

    lfsr_gen dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .seed_in (seed_in),
        .mode    (mode),
        .out     (out),
        .bit_out (bit_out),
        .wrap    (wrap),
        .period  (period),
        .lockup  (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       en;
        logic       mode;
        logic [7:0] seed_in;
        logic [7:0] exp_out;
        logic       exp_wrap;
        logic       exp_lockup;
        logic [7:0] exp_period;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic full_period(input logic m, input string tag);
        int  n;
        bit  seen_wrap;
        bit  seen_lock;
        load    = 1'b1;
        en      = 1'b0;
        seed_in = 8'h01;
        mode    = m;
        tick();
        check({tag, "_load_out"}, out, 8'h01);
        load      = 1'b0;
        en        = 1'b1;
        n         = 0;
        seen_wrap = 1'b0;
        seen_lock = 1'b0;
        while (!seen_wrap && n < 300) begin
            tick();
            n++;
            if (wrap) seen_wrap = 1'b1;
            if (lockup) seen_lock = 1'b1;
        end
        check({tag, "_wrap_seen"}, 32'(seen_wrap), 32'd1);
        check({tag, "_steps"}, n, 255);
        check({tag, "_period"}, period, 8'd255);
        check({tag, "_out"}, out, 8'h01);
        check({tag, "_no_lockup"}, 32'(seen_lock), 32'd0);
        en = 1'b0;
        tick();
        check({tag, "_wrap_one_cycle"}, wrap, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        load    = 1'b1;
        seed_in = 8'h55;
        mode    = 1'b1;

        // load, en, mode, seed_in, exp_out, wrap, lockup, period
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hB8, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h5C, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5C, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h1E, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 8'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'd2};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 8'd2};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h79, 1'b0, 1'b0, 8'd2};

        // en and load are driven high during reset and must be ignored
        tick();
        tick();
        check("rst_out", out, 8'h01);
        check("rst_bit_out", bit_out, 1'b1);
        check("rst_wrap", wrap, 1'b0);
        check("rst_lockup", lockup, 1'b0);
        check("rst_period", period, 8'd0);

        rst  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        tick();
        check("post_rst_hold", out, 8'h01);

        for (int i = 0; i < 14; i++) begin
            load    = vecs[i].load;
            en      = vecs[i].en;
            mode    = vecs[i].mode;
            seed_in = vecs[i].seed_in;
            tick();
            check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d_bit_out", i), bit_out, vecs[i].exp_out[0]);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
            check($sformatf("vec%0d_lockup", i), lockup, vecs[i].exp_lockup);
            check($sformatf("vec%0d_period", i), period, vecs[i].exp_period);
        end

        full_period(1'b1, "galois");
        full_period(1'b0, "fib");

        // asynchronous reset between edges, 100 steps into a sequence
        load    = 1'b1;
        seed_in = 8'h01;
        mode    = 1'b1;
        tick();
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("run_not_seed", 32'(out != 8'h01), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_out", out, 8'h01);
        check("async_period", period, 8'd0);
        tick();
        check("rst_held_out", out, 8'h01);
        rst = 1'b0;
        en  = 1'b0;
        tick();
        check("release_wrap", wrap, 1'b0);
        check("release_lockup", lockup, 1'b0);
        tick();
        check("release2_wrap", wrap, 1'b0);
        check("release2_lockup", lockup, 1'b0);
        en = 1'b1;
        tick();
        check("first_step_after_rst", out, 8'hB8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
